// File: rtl/led_pulse_stretch.sv
// Stretches one-cycle trigger pulses into visible LED blinks (ON_CNT lit, OFF_CNT dark).
// Triggers arriving mid-blink are counted in a saturating queue and replayed back-to-back.
module led_pulse_stretch #(
  parameter int unsigned ON_CNT    = 5000000,
  parameter int unsigned OFF_CNT   = 5000000,
  parameter int unsigned QUEUE_MAX = 7,
  localparam int unsigned PW       = $clog2(QUEUE_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          trig,
  output logic          led,
  output logic          busy,
  output logic [PW-1:0] pending,
  output logic          overflow
);

  localparam int unsigned MaxCnt = (ON_CNT > OFF_CNT) ? ON_CNT : OFF_CNT;
  localparam int unsigned TW     = (MaxCnt > 1) ? $clog2(MaxCnt) : 1;

  localparam logic [TW-1:0] OnLast  = TW'(ON_CNT - 1);
  localparam logic [TW-1:0] OffLast = TW'(OFF_CNT - 1);
  localparam logic [PW-1:0] QMax    = PW'(QUEUE_MAX);

  typedef enum logic [1:0] {StIdle, StOn, StOff} state_e;

  state_e        state_q;
  logic [TW-1:0] timer_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      timer_q  <= '0;
      pending  <= '0;
      led      <= 1'b0;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      overflow <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (trig) begin
            state_q <= StOn;
            timer_q <= '0;
            led     <= 1'b1;
            busy    <= 1'b1;
          end
        end

        StOn: begin
          if (trig) begin
            if (pending < QMax) pending <= pending + 1'b1;
            else                overflow <= 1'b1;
          end
          if (timer_q == OnLast) begin
            state_q <= StOff;
            timer_q <= '0;
            led     <= 1'b0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end

        StOff: begin
          if (timer_q == OffLast) begin
            timer_q <= '0;
            // End edge: a queued slot is consumed here, so a coincident trig can never overflow.
            if (pending != '0) begin
              state_q <= StOn;
              led     <= 1'b1;
              pending <= pending - 1'b1 + PW'(trig);
            end else if (trig) begin
              state_q <= StOn;
              led     <= 1'b1;
            end else begin
              state_q <= StIdle;
              busy    <= 1'b0;
            end
          end else begin
            timer_q <= timer_q + 1'b1;
            if (trig) begin
              if (pending < QMax) pending <= pending + 1'b1;
              else                overflow <= 1'b1;
            end
          end
        end

        default: begin
          state_q <= StIdle;
          led     <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_pulse_stretch.sv
// Directed bench for led_pulse_stretch (ON_CNT=4, OFF_CNT=3, QUEUE_MAX=2).
// Expected outputs are queued as each step is driven and popped once the DUT has responded.
module tb_led_pulse_stretch;

  localparam int unsigned OnCnt    = 4;
  localparam int unsigned OffCnt   = 3;
  localparam int unsigned QueueMax = 2;
  localparam int unsigned PW       = $clog2(QueueMax + 1);

  logic          clk;
  logic          rst;
  logic          trig;
  logic          led;
  logic          busy;
  logic [PW-1:0] pending;
  logic          overflow;

  led_pulse_stretch #(
    .ON_CNT   (OnCnt),
    .OFF_CNT  (OffCnt),
    .QUEUE_MAX(QueueMax)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .trig    (trig),
    .led     (led),
    .busy    (busy),
    .pending (pending),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          led;
    logic          busy;
    logic [PW-1:0] pend;
    logic          ovf;
    string         tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  task automatic expect_out(input logic el, input logic eb, input logic [PW-1:0] ep,
                            input logic eo, input string tag);
    exp_t e;
    e.led  = el;
    e.busy = eb;
    e.pend = ep;
    e.ovf  = eo;
    e.tag  = tag;
    exp_q.push_back(e);
  endtask

  task automatic compare_pop();
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      $error("FAIL scoreboard: observed empty queue, expected an entry");
      return;
    end
    e = exp_q.pop_front();
    assert ({led, busy, pending, overflow} === {e.led, e.busy, e.pend, e.ovf}) passes++;
    else $error("FAIL %s: observed led=%b busy=%b pending=%0d overflow=%b, expected led=%b busy=%b pending=%0d overflow=%b",
                e.tag, led, busy, pending, overflow, e.led, e.busy, e.pend, e.ovf);
  endtask

  // Drive trig for one edge, then check the outputs 1 time unit after that edge.
  task automatic step(input logic t, input logic el, input logic eb, input logic [PW-1:0] ep,
                      input logic eo, input string tag);
    expect_out(el, eb, ep, eo, tag);
    trig = t;
    @(posedge clk);
    #1;
    trig = 1'b0;
    compare_pop();
  endtask

  task automatic idle_steps(input int n, input logic el, input logic eb, input logic [PW-1:0] ep,
                            input string tag);
    for (int i = 0; i < n; i++) step(1'b0, el, eb, ep, 1'b0, tag);
  endtask

  initial begin
    rst  = 1'b0;
    trig = 1'b0;
    @(posedge clk);
    #1;

    // 1. Reset held: trig is ignored.
    for (int i = 0; i < 4; i++) step(i[0], 1'b0, 1'b0, 2'd0, 1'b0, "reset_hold");
    rst = 1'b1;
    idle_steps(3, 1'b0, 1'b0, 2'd0, "idle_after_reset");

    // 2. Single blink.
    step(1'b1, 1'b1, 1'b1, 2'd0, 1'b0, "single_on_start");
    idle_steps(3, 1'b1, 1'b1, 2'd0, "single_on");
    idle_steps(3, 1'b0, 1'b1, 2'd0, "single_off");
    step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, "single_idle");
    idle_steps(2, 1'b0, 1'b0, 2'd0, "single_idle_hold");

    // 3. Queue fills to 2, fourth trig overflows; three blinks replay.
    step(1'b1, 1'b1, 1'b1, 2'd0, 1'b0, "q_on_start");
    step(1'b1, 1'b1, 1'b1, 2'd1, 1'b0, "q_push1");
    step(1'b1, 1'b1, 1'b1, 2'd2, 1'b0, "q_push2");
    step(1'b1, 1'b1, 1'b1, 2'd2, 1'b1, "q_overflow");
    step(1'b0, 1'b0, 1'b1, 2'd2, 1'b0, "q_ovf_clear");
    idle_steps(2, 1'b0, 1'b1, 2'd2, "q_off1");
    step(1'b0, 1'b1, 1'b1, 2'd1, 1'b0, "q_blink2_start");
    idle_steps(3, 1'b1, 1'b1, 2'd1, "q_on2");
    idle_steps(3, 1'b0, 1'b1, 2'd1, "q_off2");
    step(1'b0, 1'b1, 1'b1, 2'd0, 1'b0, "q_blink3_start");
    idle_steps(3, 1'b1, 1'b1, 2'd0, "q_on3");
    idle_steps(3, 1'b0, 1'b1, 2'd0, "q_off3");
    step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, "q_idle");

    // 4. Trig on OFF end edge with empty queue: straight back to ON.
    step(1'b1, 1'b1, 1'b1, 2'd0, 1'b0, "end_on_start");
    idle_steps(3, 1'b1, 1'b1, 2'd0, "end_on");
    idle_steps(3, 1'b0, 1'b1, 2'd0, "end_off");
    step(1'b1, 1'b1, 1'b1, 2'd0, 1'b0, "end_retrig");
    idle_steps(3, 1'b1, 1'b1, 2'd0, "end_on2");
    idle_steps(3, 1'b0, 1'b1, 2'd0, "end_off2");
    step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, "end_idle");

    // 5. Trig on OFF end edge with one queued: consume plus add keeps pending at 1.
    step(1'b1, 1'b1, 1'b1, 2'd0, 1'b0, "ca_on_start");
    step(1'b1, 1'b1, 1'b1, 2'd1, 1'b0, "ca_push");
    idle_steps(2, 1'b1, 1'b1, 2'd1, "ca_on");
    idle_steps(3, 1'b0, 1'b1, 2'd1, "ca_off");
    step(1'b1, 1'b1, 1'b1, 2'd1, 1'b0, "ca_consume_add");
    idle_steps(3, 1'b1, 1'b1, 2'd1, "ca_on2");
    idle_steps(3, 1'b0, 1'b1, 2'd1, "ca_off2");
    step(1'b0, 1'b1, 1'b1, 2'd0, 1'b0, "ca_blink3_start");
    idle_steps(3, 1'b1, 1'b1, 2'd0, "ca_on3");
    idle_steps(3, 1'b0, 1'b1, 2'd0, "ca_off3");
    step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, "ca_idle");

    // 6. Asynchronous reset mid-ON with two queued.
    step(1'b1, 1'b1, 1'b1, 2'd0, 1'b0, "rst_on_start");
    step(1'b1, 1'b1, 1'b1, 2'd1, 1'b0, "rst_push1");
    step(1'b1, 1'b1, 1'b1, 2'd2, 1'b0, "rst_push2");
    #2;
    rst = 1'b0;
    #1;
    expect_out(1'b0, 1'b0, 2'd0, 1'b0, "rst_async");
    compare_pop();
    step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, "rst_held");
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, "rst_released");
    step(1'b1, 1'b1, 1'b1, 2'd0, 1'b0, "post_on_start");
    idle_steps(3, 1'b1, 1'b1, 2'd0, "post_on");
    idle_steps(3, 1'b0, 1'b1, 2'd0, "post_off");
    step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, "post_idle");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
